pipe_hazard_ctrl: RTL and testbench

Hazard and stall sequencer for the 5-stage MIPS pipeline. It works alongside the bypass unit, which resolves forwardable RAW hazards. This block handles the hazards forwarding cannot cover:
- load-use
- multi-cycle mul/div occupancy and HI/LO reads
- taken-branch/jump flush

It drives the PC/IF-DEC hold enables and the DEC-EX/IF-DEC bubble controls.

---
 rtl/pipe_hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall sequencer: load-use, mul/div occupancy, HI/LO reads, branch flush.
// Optional: define STALL_PERF_CNT_EN to build the saturating stall-cycle counter.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   if_dec_*             decode-stage register/operation info
//   dec_ex_rt/_memread   EX-stage load destination
//   branch_taken         taken redirect resolved in EX
//   md_start, md_busy    mul/div issue pulse and occupancy
//   stall_pc/_if_dec     hold enables
//   flush_if_dec/_dec_ex bubble inserts
//   stall_cnt            stall-cycle counter (0 unless STALL_PERF_CNT_EN)
module pipe_hazard_ctrl #(
  parameter int MD_LAT = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       if_dec_rs,
  input  logic [4:0]       if_dec_rt,
  input  logic             if_dec_uses_rt,
  input  logic             if_dec_is_md,
  input  logic             if_dec_reads_hilo,
  input  logic [4:0]       dec_ex_rt,
  input  logic             dec_ex_memread,
  input  logic             branch_taken,
  output logic             md_start,
  output logic             md_busy,
  output logic             stall_pc,
  output logic             stall_if_dec,
  output logic             flush_if_dec,
  output logic             flush_dec_ex,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [5:0] r_md_cnt;
  logic [5:0] w_md_cnt_nxt;

  logic w_busy;
  logic w_lu;
  logic w_hl;
  logic w_stall;
  logic w_issue;

  always_comb begin
    w_busy = (r_state == MD_BUSY);
    w_lu   = dec_ex_memread && (dec_ex_rt != 5'd0) &&
             ((dec_ex_rt == if_dec_rs) ||
              (if_dec_uses_rt && (dec_ex_rt == if_dec_rt)));
    w_hl   = w_busy && (if_dec_reads_hilo || if_dec_is_md);
    w_stall = (w_lu || w_hl) && !branch_taken;
    // Busy already blocks issue via hl, so issue only from IDLE.
    w_issue = !w_busy && if_dec_is_md && !w_lu && !branch_taken;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_md_cnt <= 6'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_issue) begin
          w_state_nxt  = MD_BUSY;
          w_md_cnt_nxt = 6'(MD_LAT - 1);
        end
      end
      MD_BUSY: begin
        if (r_md_cnt == 6'd0) begin
          w_state_nxt = IDLE;
        end else begin
          w_md_cnt_nxt = r_md_cnt - 6'd1;
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_md_cnt_nxt = 6'd0;
      end
    endcase
  end

  // Outputs forced low while reset is held.
  always_comb begin
    md_start     = w_issue && !reset;
    md_busy      = w_busy && !reset;
    stall_pc     = w_stall && !reset;
    stall_if_dec = w_stall && !reset;
    flush_if_dec = branch_taken && !reset;
    flush_dec_ex = (w_stall || branch_taken) && !reset;
  end

`ifdef STALL_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (stall_pc && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios plus random traffic
// checked against a cycle-count based reference model.
module tb_pipe_hazard_ctrl;

  localparam int MD_LAT = 4;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] if_dec_rs, if_dec_rt, dec_ex_rt;
  logic if_dec_uses_rt, if_dec_is_md, if_dec_reads_hilo;
  logic dec_ex_memread, branch_taken;
  logic md_start, md_busy, stall_pc, stall_if_dec;
  logic flush_if_dec, flush_dec_ex;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .if_dec_rs(if_dec_rs), .if_dec_rt(if_dec_rt),
    .if_dec_uses_rt(if_dec_uses_rt), .if_dec_is_md(if_dec_is_md),
    .if_dec_reads_hilo(if_dec_reads_hilo),
    .dec_ex_rt(dec_ex_rt), .dec_ex_memread(dec_ex_memread),
    .branch_taken(branch_taken),
    .md_start(md_start), .md_busy(md_busy),
    .stall_pc(stall_pc), .stall_if_dec(stall_if_dec),
    .flush_if_dec(flush_if_dec), .flush_dec_ex(flush_dec_ex),
    .stall_cnt(stall_cnt)
  );

`ifdef STALL_PERF_CNT_EN
  logic s2_start, s2_busy, s2_spc, s2_sid, s2_fid, s2_fde;
  logic [1:0] s2_cnt;
  pipe_hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset),
    .if_dec_rs(if_dec_rs), .if_dec_rt(if_dec_rt),
    .if_dec_uses_rt(if_dec_uses_rt), .if_dec_is_md(if_dec_is_md),
    .if_dec_reads_hilo(if_dec_reads_hilo),
    .dec_ex_rt(dec_ex_rt), .dec_ex_memread(dec_ex_memread),
    .branch_taken(branch_taken),
    .md_start(s2_start), .md_busy(s2_busy),
    .stall_pc(s2_spc), .stall_if_dec(s2_sid),
    .flush_if_dec(s2_fid), .flush_dec_ex(s2_fde),
    .stall_cnt(s2_cnt)
  );
`endif

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: cycle index and cycle of the last md issue.
  int cyc_n = 0;
  int last_issue = -1000;
  int cnt_m = 0;
  int cnt2_m = 0;
  bit cnt_ok = 0;
  logic last_stall, last_start;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc_n);
    end
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic md,
                       input logic hilo, input logic [4:0] exrt,
                       input logic mr, input logic bt, input logic rst);
    logic lu, busy, hl, st, iss;
    @(negedge clk);
    if_dec_rs = rs; if_dec_rt = rt; if_dec_uses_rt = urt;
    if_dec_is_md = md; if_dec_reads_hilo = hilo;
    dec_ex_rt = exrt; dec_ex_memread = mr;
    branch_taken = bt; reset = rst;
    #1;
    lu = mr && exrt != 0 && (exrt == rs || (urt && exrt == rt));
    busy = (cyc_n - last_issue >= 1) && (cyc_n - last_issue <= MD_LAT);
    hl = busy && (hilo || md);
    st = (lu || hl) && !bt && !rst;
    iss = md && !lu && !bt && !busy && !rst;
    chk("md_start", md_start, iss);
    chk("md_busy", md_busy, busy && !rst);
    chk("stall_pc", stall_pc, st);
    chk("stall_if_dec", stall_if_dec, st);
    chk("flush_if_dec", flush_if_dec, bt && !rst);
    chk("flush_dec_ex", flush_dec_ex, (st || bt) && !rst);
`ifdef STALL_PERF_CNT_EN
    if (cnt_ok) begin
      chk("stall_cnt", 32'(stall_cnt), cnt_m);
      chk("stall_cnt_w2", 32'(s2_cnt), cnt2_m);
    end
`else
    chk("stall_cnt", 32'(stall_cnt), 0);
`endif
    last_stall = stall_pc;
    last_start = md_start;
    @(posedge clk);
    cyc_n++;
    if (rst) begin
      last_issue = -1000;
      cnt_m = 0;
      cnt2_m = 0;
      cnt_ok = 1;
    end else begin
      if (iss) last_issue = cyc_n - 1;
      if (st) begin
        if (cnt_m < (1 << CNT_W) - 1) cnt_m++;
        if (cnt2_m < 3) cnt2_m++;
      end
    end
  endtask

  task automatic idle(input logic rst);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, rst);
  endtask

  int stalls;

  initial begin
    idle(1'b1);
    idle(1'b1);
    chk("rst_busy", md_busy, 1'b0);
    idle(1'b0);

    // Load-use on rs: exactly one stall cycle.
    drive(5'd5, 5'd1, 1'b1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    chk("lu_stall", last_stall, 1'b1);
    drive(5'd5, 5'd1, 1'b1, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0);
    chk("lu_release", last_stall, 1'b0);

    // mult then mflo: four stall cycles.
    drive(5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("md_pulse", last_start, 1'b1);
    stalls = 0;
    for (int i = 0; i < 10; i++) begin
      drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      if (!last_stall) break;
      stalls++;
    end
    chk("mflo_stalls", stalls, MD_LAT);
`ifdef STALL_PERF_CNT_EN
    idle(1'b0);
    chk("cnt_total", 32'(stall_cnt), 5);
    chk("cnt_sat", 32'(s2_cnt), 3);
`endif

    // r0 never hazards; rt ignored when not a source.
    drive(5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("r0_nostall", last_stall, 1'b0);
    drive(5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    chk("rt_unused", last_stall, 1'b0);
    drive(5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    chk("rt_used", last_stall, 1'b1);

    // Branch beats load-use and md issue.
    drive(5'd6, 5'd1, 1'b1, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
    chk("br_nostall", last_stall, 1'b0);
    chk("br_nostart", last_start, 1'b0);

    // Back-to-back md ops: one idle cycle between windows.
    drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < MD_LAT + 1; i++)
      drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("md_reissue", last_start, 1'b1);
    for (int i = 0; i < MD_LAT; i++) idle(1'b0);

    // Reset in second busy cycle abandons the op.
    drive(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);
    chk("rst_abandon", md_busy, 1'b0);
    chk("rst_cnt", 32'(stall_cnt), 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 3) == 0),
            5'($urandom_range(0, 7)), 1'($urandom),
            1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 63) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
